video_scanline_fx: RTL

Parametrised final-stage video mixer for the `clk_vid` domain. It takes native-width core RGB plus sync and blank signals. It expands colour to 8 bits per channel and applies 8-level scanline darkening with a programmable line period and phase. It generates DE from the blanking signals and measures lines per frame. It sits after any scandoubler or gamma stage and drives the VGA_* outputs.

---
 rtl/video_scanline_fx.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/video_scanline_fx.sv
// Final video output stage: colour expansion to 8 bits, scanline darkening,
// DE generation from blanking, and a lines-per-frame counter.
module video_scanline_fx #(
    parameter int DW        = 8,
    parameter int MONO_EN   = 1,
    parameter int SL_PERIOD = 2,
    parameter int PW        = 4
) (
    input  logic          clk_vid,
    input  logic          reset,
    input  logic          ce_pix,
    input  logic [DW-1:0] R,
    input  logic [DW-1:0] G,
    input  logic [DW-1:0] B,
    input  logic          mono,
    input  logic          HSync,
    input  logic          VSync,
    input  logic          HBlank,
    input  logic          VBlank,
    input  logic [2:0]    scanlines,
    input  logic [PW-1:0] sl_phase,
    output logic          ce_pix_out,
    output logic [7:0]    VGA_R,
    output logic [7:0]    VGA_G,
    output logic [7:0]    VGA_B,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          VGA_DE,
    output logic [11:0]   line_total
);

    localparam int LCW = 4;
    localparam logic [LCW-1:0] LINE_LAST = LCW'(SL_PERIOD - 1);

    // MSB-first bit replication, truncated to 8 bits
    function automatic logic [7:0] expand(input logic [DW-1:0] x);
        logic [8*DW-1:0] rep;
        rep = {8{x}};
        return rep[8*DW-1 -: 8];
    endfunction

    function automatic logic [7:0] darken(input logic [7:0] v, input logic [2:0] k);
        logic [10:0] prod;
        prod = {3'b000, v} * {7'b0000000, 4'd8 - {1'b0, k}};
        return prod[10:3];
    endfunction

    logic           old_hs_q, old_vs_q, old_hde_q, v_de_q;
    logic [LCW-1:0] line_cnt_q;
    logic [11:0]    hs_cnt_q, line_total_q;
    logic [7:0]     r1_q, g1_q, b1_q;
    logic           hs1_q, vs1_q;
    logic [7:0]     r2_q, g2_q, b2_q;
    logic           hs2_q, vs2_q, de2_q;

    logic           hs_fall, vs_fall, dark, use_mono;
    logic [7:0]     exp_r, exp_g, exp_b, src_r, src_b;
    logic [7:0]     r1_d, g1_d, b1_d;
    logic           v_de_d;
    logic [LCW-1:0] line_cnt_d;
    logic [11:0]    hs_cnt_d, line_total_d;

    always_comb begin
        hs_fall  = old_hs_q & ~HSync;
        vs_fall  = old_vs_q & ~VSync;
        use_mono = (MONO_EN != 0) && mono;

        exp_r = expand(R);
        exp_g = expand(G);
        exp_b = expand(B);
        src_r = use_mono ? exp_g : exp_r;
        src_b = use_mono ? exp_g : exp_b;

        // Phase values beyond the group length never match
        dark = (32'(line_cnt_q) == 32'(sl_phase)) && (scanlines != 3'd0);
        r1_d = dark ? darken(src_r, scanlines) : src_r;
        g1_d = dark ? darken(exp_g, scanlines) : exp_g;
        b1_d = dark ? darken(src_b, scanlines) : src_b;

        v_de_d = v_de_q;
        if (~HBlank && ~old_hde_q) begin
            v_de_d = ~VBlank;
        end else if (HBlank && old_hde_q) begin
            v_de_d = 1'b0;
        end

        line_cnt_d = line_cnt_q;
        if (vs_fall) begin
            line_cnt_d = '0;
        end else if (hs_fall) begin
            line_cnt_d = (line_cnt_q == LINE_LAST) ? '0 : line_cnt_q + 1'b1;
        end

        hs_cnt_d     = hs_cnt_q;
        line_total_d = line_total_q;
        if (vs_fall) begin
            // A coincident HSync fall is the first line of the new frame
            line_total_d = hs_cnt_q;
            hs_cnt_d     = hs_fall ? 12'd1 : 12'd0;
        end else if (hs_fall && hs_cnt_q != 12'hFFF) begin
            hs_cnt_d = hs_cnt_q + 12'd1;
        end
    end

    always_ff @(posedge clk_vid) begin
        if (reset) begin
            old_hs_q     <= 1'b0;
            old_vs_q     <= 1'b0;
            old_hde_q    <= 1'b0;
            v_de_q       <= 1'b0;
            line_cnt_q   <= '0;
            hs_cnt_q     <= '0;
            line_total_q <= '0;
            r1_q         <= '0;
            g1_q         <= '0;
            b1_q         <= '0;
            hs1_q        <= 1'b0;
            vs1_q        <= 1'b0;
            r2_q         <= '0;
            g2_q         <= '0;
            b2_q         <= '0;
            hs2_q        <= 1'b0;
            vs2_q        <= 1'b0;
            de2_q        <= 1'b0;
        end else begin
            old_hs_q     <= HSync;
            old_vs_q     <= VSync;
            line_cnt_q   <= line_cnt_d;
            hs_cnt_q     <= hs_cnt_d;
            line_total_q <= line_total_d;
            if (ce_pix) begin
                r1_q      <= r1_d;
                g1_q      <= g1_d;
                b1_q      <= b1_d;
                hs1_q     <= HSync;
                vs1_q     <= VSync;
                old_hde_q <= ~HBlank;
                v_de_q    <= v_de_d;
                r2_q      <= r1_q;
                g2_q      <= g1_q;
                b2_q      <= b1_q;
                hs2_q     <= hs1_q;
                vs2_q     <= vs1_q;
                de2_q     <= v_de_q;
            end
        end
    end

    assign ce_pix_out = ce_pix;
    assign VGA_R      = r2_q;
    assign VGA_G      = g2_q;
    assign VGA_B      = b2_q;
    assign VGA_HS     = hs2_q;
    assign VGA_VS     = vs2_q;
    assign VGA_DE     = de2_q;
    assign line_total = line_total_q;

endmodule
